// File: rtl/pipe_ctrl_n_if.sv
// Control bundle between the pipeline request logic and pipe_ctrl_n:
// per-stage stall/flush requests in, keep/dirty vectors and counters out.
interface pipe_ctrl_n_if #(
  parameter int unsigned N     = 5,
  parameter int unsigned CNT_W = 16
) ();
  logic             freeze;
  logic [N-1:0]     stall;
  logic [N-1:0]     flush;
  logic             clr_cnt;
  logic [N-1:0]     keep;
  logic [N-1:0]     dirty;
  logic             stall_expire;
  logic [CNT_W-1:0] retired_cnt;
  logic [CNT_W-1:0] bubble_cnt;

  modport master (
    output freeze, stall, flush, clr_cnt,
    input  keep, dirty, stall_expire, retired_cnt, bubble_cnt
  );

  modport slave (
    input  freeze, stall, flush, clr_cnt,
    output keep, dirty, stall_expire, retired_cnt, bubble_cnt
  );
endinterface

// File: rtl/pipe_ctrl_n.sv
// N-stage in-order pipeline control: per-stage keep/dirty generation with freeze,
// flush, stall priority, a consecutive-stall watchdog and saturating perf counters.
module pipe_ctrl_n #(
  parameter int unsigned N         = 5,
  parameter int unsigned MAX_STALL = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic         clk,
  input  logic         rst,
  pipe_ctrl_n_if.slave ctl
);

  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned WD_W  = (MAX_STALL > 0) ? $clog2(MAX_STALL + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    M_RESET,
    M_FREEZE,
    M_FLUSH,
    M_STALL,
    M_ADVANCE
  } mode_e;

  mode_e            mode;
  logic [N-1:0]     dirty_q, dirty_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [CNT_W-1:0] ret_q, ret_d;
  logic [CNT_W-1:0] bub_q, bub_d;
  logic [N-1:0]     keep_c;
  logic             expire_c;
  logic [IDX_W-1:0] flush_idx;
  logic [IDX_W-1:0] stall_idx;
  logic             flush_any;
  logic             stall_any;
  logic             wd_hit;

  // Lowest set request index: the most downstream flush/stall wins.
  always_comb begin
    flush_idx = '0;
    stall_idx = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (ctl.flush[j]) flush_idx = IDX_W'(j);
      if (ctl.stall[j]) stall_idx = IDX_W'(j);
    end
  end

  assign flush_any = |ctl.flush;
  assign stall_any = |ctl.stall;
  assign wd_hit    = (MAX_STALL > 0) && (wd_q == WD_W'(MAX_STALL));

  always_comb begin
    if (!rst)                        mode = M_RESET;
    else if (ctl.freeze)             mode = M_FREEZE;
    else if (flush_any)              mode = M_FLUSH;
    else if (stall_any && !wd_hit)   mode = M_STALL;
    else                             mode = M_ADVANCE;
  end

  // Next-state and combinational outputs; keep never depends on dirty.
  always_comb begin
    keep_c   = '0;
    expire_c = 1'b0;
    dirty_d  = dirty_q;
    wd_d     = wd_q;
    ret_d    = ret_q;
    bub_d    = bub_q;

    unique case (mode)
      M_RESET: ;
      M_FREEZE: keep_c = '1;
      M_FLUSH: begin
        wd_d = '0;
        for (int j = 0; j < N - 1; j++) begin
          dirty_d[j] = (IDX_W'(j) >= flush_idx) ? 1'b1 : dirty_q[j+1];
        end
        dirty_d[N-1] = 1'b0;
      end
      M_STALL: begin
        wd_d = (MAX_STALL > 0) ? wd_q + WD_W'(1) : '0;
        for (int j = 0; j < N; j++) begin
          keep_c[j] = (IDX_W'(j) >= stall_idx);
        end
        for (int j = 0; j < N - 1; j++) begin
          if (IDX_W'(j) >= stall_idx)          dirty_d[j] = dirty_q[j];
          else if (IDX_W'(j + 1) == stall_idx) dirty_d[j] = 1'b1;
          else                                 dirty_d[j] = dirty_q[j+1];
        end
      end
      M_ADVANCE: begin
        wd_d     = '0;
        expire_c = stall_any && wd_hit;
        dirty_d  = {1'b0, dirty_q[N-1:1]};
      end
      default: ;
    endcase

    // Counters move only on live, unfrozen cycles; clear beats increment.
    if (mode != M_RESET && mode != M_FREEZE) begin
      if (ctl.clr_cnt) begin
        ret_d = '0;
        bub_d = '0;
      end else begin
        if (!dirty_q[0] && !keep_c[0] && ret_q != CNT_MAX) ret_d = ret_q + CNT_W'(1);
        if (dirty_q[0] && bub_q != CNT_MAX)                bub_d = bub_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      dirty_q <= '1;
      wd_q    <= '0;
      ret_q   <= '0;
      bub_q   <= '0;
    end else begin
      dirty_q <= dirty_d;
      wd_q    <= wd_d;
      ret_q   <= ret_d;
      bub_q   <= bub_d;
    end
  end

  assign ctl.keep         = keep_c;
  assign ctl.dirty        = dirty_q;
  assign ctl.stall_expire = expire_c;
  assign ctl.retired_cnt  = ret_q;
  assign ctl.bubble_cnt   = bub_q;

endmodule
